// File: rtl/waxwing_trace_buf.sv
// -----------------------------------------------------------------------------
// waxwing_trace_buf
//
// Trigger-centred trace capture buffer. Once armed, every qualified sample is
// written into a circular buffer; the oldest entry is overwritten when the
// buffer is full. A qualified trigger starts a post-trigger window of
// POST_TRIG further samples. After that window the buffer freezes and the
// captured history can be popped oldest-first.
//
// Parameters
//   WIDTH      bits per captured sample
//   DEPTH      buffer entries (power of two, >= 4)
//   POST_TRIG  samples kept after the trigger sample (< DEPTH)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   sample_in     sample to capture
//   sample_valid  sample_in qualifies this cycle
//   arm           start a new capture (from IDLE or DONE)
//   trig_in       trigger condition, only honoured with sample_valid
//   rd_en         pop the oldest captured entry (DONE only)
//   rd_data       popped sample, registered
//   rd_valid      one-cycle pulse qualifying rd_data
//   state         0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   done          high while state is DONE
//   count         unread entries held
//   trig_idx      readout position of the trigger sample, valid in DONE
// -----------------------------------------------------------------------------
module waxwing_trace_buf #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           sample_in,
    input  logic                       sample_valid,
    input  logic                       arm,
    input  logic                       trig_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [1:0]                 state,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   trig_idx
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);
    localparam logic [AW-1:0] TRIG_OFS  = AW'(POST_TRIG + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     post_cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              capturing;
    logic              write_en;
    logic [AW-1:0]     wr_ptr_inc;
    logic [AW:0]       count_inc;
    logic [AW-1:0]     rd_ptr_done;
    logic [AW-1:0]     trig_idx_done;

    assign state = state_q;
    assign done  = (state_q == S_DONE);

    // Values as they will stand after this cycle's write. On DONE entry the
    // final sample is written in the same cycle, so the read pointer and the
    // trigger position are derived from these post-write values. When the
    // buffer is full count_inc[AW-1:0] is zero and rd_ptr_done lands on the
    // oldest surviving entry, which is the slot about to be overwritten next.
    always_comb begin
        capturing     = (state_q == S_ARMED) || (state_q == S_POST);
        write_en      = !reset && capturing && sample_valid;
        wr_ptr_inc    = wr_ptr + AW'(1);
        count_inc     = (count == CNT_FULL) ? count : count + (AW+1)'(1);
        rd_ptr_done   = wr_ptr_inc - count_inc[AW-1:0];
        trig_idx_done = count_inc[AW-1:0] - TRIG_OFS;
    end

    // Sample storage is not reset; stale contents are unreachable because
    // count is cleared whenever a new capture starts or reset is applied.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            count    <= '0;
            trig_idx <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_q <= S_ARMED;
                        count   <= '0;
                        wr_ptr  <= '0;
                    end
                end

                S_ARMED: begin
                    if (sample_valid) begin
                        wr_ptr <= wr_ptr_inc;
                        count  <= count_inc;
                        if (trig_in) begin
                            if (POST_TRIG == 0) begin
                                state_q  <= S_DONE;
                                rd_ptr   <= rd_ptr_done;
                                trig_idx <= trig_idx_done;
                            end else begin
                                state_q  <= S_POST;
                                post_cnt <= POST_LOAD;
                            end
                        end
                    end
                end

                // Only qualified samples advance the post-trigger window.
                S_POST: begin
                    if (sample_valid) begin
                        wr_ptr   <= wr_ptr_inc;
                        count    <= count_inc;
                        post_cnt <= post_cnt - AW'(1);
                        if (post_cnt == AW'(1)) begin
                            state_q  <= S_DONE;
                            rd_ptr   <= rd_ptr_done;
                            trig_idx <= trig_idx_done;
                        end
                    end
                end

                // arm takes priority over a pop issued in the same cycle.
                S_DONE: begin
                    if (arm) begin
                        state_q <= S_ARMED;
                        count   <= '0;
                        wr_ptr  <= '0;
                    end else if (rd_en && (count != '0)) begin
                        rd_data  <= mem[rd_ptr];
                        rd_valid <= 1'b1;
                        count    <= count - (AW+1)'(1);
                        rd_ptr   <= rd_ptr + AW'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_waxwing_trace_buf.sv
// -----------------------------------------------------------------------------
// tb_waxwing_trace_buf
//
// Self-checking bench for waxwing_trace_buf (WIDTH 32, DEPTH 16, POST_TRIG 4).
// A queue-based reference model holds the captured history; every cycle the
// DUT outputs are compared with it. Directed scenarios cover the documented
// capture/readout cases, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_waxwing_trace_buf;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 4;

    logic              clk;
    logic              reset;
    logic [WIDTH-1:0]  sample_in;
    logic              sample_valid;
    logic              arm;
    logic              trig_in;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic [1:0]        state;
    logic              done;
    logic [4:0]        count;
    logic [3:0]        trig_idx;

    int checks   = 0;
    int failures = 0;

    // Reference model: captured entries, oldest first.
    logic [WIDTH-1:0]  m_q[$];
    int                m_state;
    int                m_post;
    int                m_tidx;
    logic              m_rdv;
    logic [WIDTH-1:0]  m_rdd;

    waxwing_trace_buf #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .POST_TRIG(POST_TRIG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .arm         (arm),
        .trig_in     (trig_in),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .state       (state),
        .done        (done),
        .count       (count),
        .trig_idx    (trig_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_push(input logic [WIDTH-1:0] s);
        m_q.push_back(s);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
    endtask

    task automatic model_enter_done();
        m_state = 3;
        m_tidx  = m_q.size() - 1 - POST_TRIG;
    endtask

    // Applies one cycle of the behavioural rules to the model.
    task automatic model_step(input logic r, input logic a, input logic v,
                              input logic t, input logic rd, input logic [WIDTH-1:0] s);
        m_rdv = 1'b0;
        if (r) begin
            m_state = 0;
            m_q.delete();
            m_rdd  = '0;
            m_tidx = 0;
            m_post = 0;
        end else begin
            case (m_state)
                0: if (a) begin m_state = 1; m_q.delete(); end
                1: if (v) begin
                       model_push(s);
                       if (t) begin
                           if (POST_TRIG == 0) model_enter_done();
                           else begin m_state = 2; m_post = POST_TRIG; end
                       end
                   end
                2: if (v) begin
                       model_push(s);
                       m_post--;
                       if (m_post == 0) model_enter_done();
                   end
                default: begin
                    if (a) begin
                        m_state = 1;
                        m_q.delete();
                    end else if (rd && m_q.size() > 0) begin
                        m_rdd = m_q.pop_front();
                        m_rdv = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic v,
                                 input logic t, input logic rd, input logic [WIDTH-1:0] s);
        reset        = r;
        arm          = a;
        sample_valid = v;
        trig_in      = t;
        rd_en        = rd;
        sample_in    = s;
        @(posedge clk);
        model_step(r, a, v, t, rd, s);
        #1;
        checkOutput("state",    64'(state),    64'(m_state));
        checkOutput("count",    64'(count),    64'(m_q.size()));
        checkOutput("done",     64'(done),     64'(m_state == 3));
        checkOutput("rd_valid", 64'(rd_valid), 64'(m_rdv));
        checkOutput("rd_data",  64'(rd_data),  64'(m_rdd));
        checkOutput("trig_idx", 64'(trig_idx), 64'(m_tidx & (DEPTH - 1)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic sample(input logic t, input logic [WIDTH-1:0] s);
        applyStimulus(1'b0, 1'b0, 1'b1, t, 1'b0, s);
    endtask

    task automatic pop();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic do_arm();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        m_q.delete();
        m_state = 0; m_post = 0; m_tidx = 0; m_rdv = 1'b0; m_rdd = '0;
        reset = 1'b1; arm = 1'b0; sample_valid = 1'b0; trig_in = 1'b0;
        rd_en = 1'b0; sample_in = '0;

        // Reset held two cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("reset_state",    64'(state),    64'd0);
        checkOutput("reset_count",    64'(count),    64'd0);
        checkOutput("reset_rd_data",  64'(rd_data),  64'd0);

        // Samples while IDLE are ignored; arm+trig in IDLE: arm wins.
        sample(1'b1, 32'hDEAD);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hBEEF);
        checkOutput("idle_arm_trig_state", 64'(state), 64'd1);
        checkOutput("idle_arm_trig_count", 64'(count), 64'd0);

        // Short capture: 1..5, trigger on 6, 7..10.
        for (int i = 1; i <= 10; i++) sample(i == 6, 32'(i));
        checkOutput("short_state", 64'(state),    64'd3);
        checkOutput("short_count", 64'(count),    64'd10);
        checkOutput("short_tidx",  64'(trig_idx), 64'd5);
        for (int i = 1; i <= 10; i++) begin
            pop();
            checkOutput("short_rd_data",  64'(rd_data),  64'(i));
            checkOutput("short_rd_valid", 64'(rd_valid), 64'd1);
        end
        checkOutput("short_empty", 64'(count), 64'd0);

        // Pop with nothing left.
        pop();
        checkOutput("empty_pop_valid", 64'(rd_valid), 64'd0);
        checkOutput("empty_pop_data",  64'(rd_data),  64'd10);

        // Wrapping capture: 1..20, trigger on 21, 22..25.
        do_arm();
        checkOutput("rearm_count", 64'(count), 64'd0);
        for (int i = 1; i <= 25; i++) sample(i == 21, 32'(i));
        checkOutput("wrap_count", 64'(count),    64'd16);
        checkOutput("wrap_tidx",  64'(trig_idx), 64'd11);
        for (int i = 0; i < 16; i++) begin
            pop();
            checkOutput("wrap_rd_data", 64'(rd_data), 64'(10 + i));
        end

        // POST with gaps, trig pulses and arm that must be ignored.
        do_arm();
        sample(1'b0, 32'h100);
        sample(1'b1, 32'h101);
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        sample(1'b1, 32'h102);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        sample(1'b0, 32'h103);
        idle(1);
        sample(1'b1, 32'h104);
        checkOutput("post_gap_state", 64'(state), 64'd2);
        sample(1'b0, 32'h105);
        checkOutput("post_end_state", 64'(state),    64'd3);
        checkOutput("post_end_tidx",  64'(trig_idx), 64'd1);

        // arm and rd_en together in DONE: arm wins.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        checkOutput("arm_vs_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("arm_vs_rd_state", 64'(state),    64'd1);

        // Reset in the middle of POST.
        sample(1'b1, 32'h200);
        sample(1'b0, 32'h201);
        sample(1'b0, 32'h202);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h203);
        checkOutput("mid_post_reset_state", 64'(state), 64'd0);
        checkOutput("mid_post_reset_count", 64'(count), 64'd0);
        pop();
        checkOutput("mid_post_reset_rd", 64'(rd_valid), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) < 5,
                          $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
